// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: register file geometry,
// default outstanding-operation limit, and the counter width helper.
package reg_scoreboard_pkg;

  localparam int NREG        = 32;
  localparam int AW          = 5;
  localparam int MAX_OUT_DEF = 4;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/sb_busy_table.sv
// Busy table: one bit per architectural register. Clear from writeback,
// set from issue (set wins on the same register), flush overrides both.
// Register 0 is hardwired not-busy. Two combinational read ports serve
// the two source operands of the decode instruction.
module sb_busy_table
  import reg_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            flush,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [NREG-1:0] busy_vec,
  output logic            busy_a,
  output logic            busy_b
);

  logic [NREG-1:0] busy_q, busy_d;

  // Next-state: clear, then set (so set wins), then flush overrides all.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (clr_en && (clr_addr == AW'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_addr == AW'(i))) busy_d[i] = 1'b1;
    end
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // State register with synchronous reset; nothing updates while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign busy_a   = busy_q[rd_addr_a];
  assign busy_b   = busy_q[rd_addr_b];

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency operations. Sets a busy bit when a
// long op issues, clears it at writeback, and stalls decode on RAW/WAW
// hazards against busy registers or when MAX_OUT ops are already in flight.
// Optional macro SCOREBOARD_BYPASS_EN: a same-cycle writeback masks its
// register from the hazard checks and frees one slot combinationally.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AW-1:0]               ra1_r,
  input  logic [AW-1:0]               ra2_r,
  input  logic [AW-1:0]               rd_r,
  input  logic                        rd_we_r,
  input  logic                        long_r,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  output logic                        stall,
  input  logic                        wb_valid,
  input  logic [AW-1:0]               wb_addr,
  input  logic                        flush,
  output logic [NREG-1:0]             busy_vec,
  output logic [cnt_w(MAX_OUT)-1:0]   outstanding
);

  localparam int CW = cnt_w(MAX_OUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_a, busy_b;
  logic          eb1, eb2, ebd;
  logic          wb_free;
  logic          raw, waw, full;
  logic          fire, dec;
  logic          set_en;

  sb_busy_table u_busy (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_addr  (rd_r),
    .clr_en    (wb_valid),
    .clr_addr  (wb_addr),
    .flush     (flush),
    .rd_addr_a (ra1_r),
    .rd_addr_b (ra2_r),
    .busy_vec  (busy_vec),
    .busy_a    (busy_a),
    .busy_b    (busy_b)
  );

  // Hazard detection against effective busy state; gated off in reset.
  always_comb begin
    eb1     = busy_a;
    eb2     = busy_b;
    ebd     = busy_vec[rd_r];
    wb_free = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (wb_valid && (wb_addr == ra1_r)) eb1 = 1'b0;
    if (wb_valid && (wb_addr == ra2_r)) eb2 = 1'b0;
    if (wb_valid && (wb_addr == rd_r))  ebd = 1'b0;
    wb_free = wb_valid;
`else
    wb_free = 1'b0;
`endif
    raw   = ((ra1_r != '0) && eb1) || ((ra2_r != '0) && eb2);
    waw   = rd_we_r && (rd_r != '0) && ebd;
    full  = long_r && (cnt_q == CW'(MAX_OUT)) && !wb_free;
    stall = rst_n && issue_valid && (raw || waw || full);
    fire  = rst_n && issue_valid && !stall && long_r;
    set_en = fire && rd_we_r && (rd_r != '0);
  end

  assign issue_ready = ~stall;

  // Outstanding counter: +1 on fire, -1 on completion (saturating at 0),
  // simultaneous fire and completion leave it unchanged; flush zeroes it.
  always_comb begin
    dec   = wb_valid && ((cnt_q != '0) || fire);
    cnt_d = cnt_q;
    if (fire && !dec)      cnt_d = cnt_q + CW'(1);
    else if (!fire && dec) cnt_d = cnt_q - CW'(1);
    if (flush) cnt_d = '0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign outstanding = cnt_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks destination registers of in-flight long-latency operations (multi-cycle loads, mul/div) between issue in the decode/register-read stage and completion at writeback. It is the producer-side complement to the forwarding/stall logic: where the forwarding unit resolves hazards against the fixed E and M pipeline slots, this block sets a busy bit at issue and clears it on completion. It raises `stall` for RAW and WAW hazards and for back-pressure on the outstanding-operation limit. It sits beside the register file and feeds the pipeline keep/stall path.

## Interface
- `NREG`, 32, number of architectural registers
- `AW`, 5, register address width
- `MAX_OUT`, 4, maximum outstanding long-latency operations (≥1)

- `clk` in 1 — clock, rising edge
- `rst_n` in 1 — synchronous active-low reset
- `ra1_r`, `ra2_r` in AW — source registers of the instruction in decode
- `rd_r` in AW — destination register of the instruction in decode
- `rd_we_r` in 1 — decode instruction writes `rd_r`
- `long_r` in 1 — decode instruction dispatches to a long-latency unit
- `issue_valid` in 1 — decode instruction is valid and attempting to issue
- `issue_ready` out 1 — equals `~stall`
- `stall` out 1 — hold decode this cycle
- `wb_valid` in 1 — long-latency completion this cycle
- `wb_addr` in AW — destination register of the completion
- `flush` in 1 — discard all pending entries
- `busy_vec` out NREG — registered busy bits; bit 0 always 0
- `outstanding` out clog2(MAX_OUT+1) — registered in-flight count

## Operation
- **Effective busy:** `eb[i] = busy[i]`. With bypass enabled (see Configuration), also `& ~(wb_valid & wb_addr==i)`.
- **Stall terms:**
  - RAW: (`ra1_r`≠0 & eb[`ra1_r`]) | (`ra2_r`≠0 & eb[`ra2_r`]).
  - WAW: `rd_we_r` & `rd_r`≠0 & eb[`rd_r`].
  - FULL: `long_r` & `outstanding`==MAX_OUT & ~(bypass enabled & `wb_valid`).
  - `stall` = `issue_valid` & (RAW | WAW | FULL). When `issue_valid`=0, `stall`=0.
- **Issue fire:** `issue_valid` & ~`stall` & `long_r`.
  - Increments the count.
  - If `rd_we_r` & `rd_r`≠0, sets busy[`rd_r`].
- **Completion:** `wb_valid` clears busy[`wb_addr`] and decrements the count.
  - `wb_addr`=0 still decrements.
  - `wb_valid` with count 0: count holds at 0 (saturating), clear still applied.
- **Simultaneous fire and completion:**
  - Count is unchanged.
  - Same register (only reachable with bypass): the set wins, so busy stays 1.
- **Flush:** next cycle busy=0 and count=0, overriding any same-cycle fire or completion. The long-latency units are flushed by the same signal and drop their completions.
- **Reset:** `busy_vec`=0, `outstanding`=0. During reset, `stall` is forced 0 and `issue_ready` is 1; no state updates occur.

## Timing
- `stall` and `issue_ready` are combinational from registered state plus the current-cycle inputs.
- A busy bit set by a fire at edge N is visible to the decode instruction in cycle N+1.
- Without bypass, a completion in cycle N clears the hazard from cycle N+1 (1-cycle penalty).
- With bypass, a completion in cycle N releases the stall in cycle N itself.
- `busy_vec` and `outstanding` are registered and reflect state after the last edge.
- No multi-cycle internal states exist. The only state is the busy table plus the up/down counter.

## Configuration
- **`SCOREBOARD_BYPASS_EN` defined:** a same-cycle `wb_valid` masks its register from RAW/WAW checks and frees one FULL slot combinationally.
- **Undefined:** hazard checks use registered state only. This shortens the critical path and costs one stall cycle per dependent completion.

## Structure
- **Shared package:** `NREG`, `AW`, the `MAX_OUT` default, and the count-width function.
- **Sub-module `sb_busy_table`:** the NREG-bit register with set/clear/flush priority and two read ports. The top module holds the counter and stall logic.

## Test plan
- **Reset, then idle:** hold `rst_n`=0 for 2 cycles with `issue_valid`=1 → `stall`=0, `busy_vec`=0, `outstanding`=0.
- **RAW stall:** fire long op with `rd_r`=5, then decode `ra1_r`=5 → `stall`=1 until `wb_valid`/`wb_addr`=5. Stall drops the same cycle with bypass enabled, the next cycle without.
- **WAW and x0:** fire long op with `rd_r`=0 → `busy_vec`=0 and `outstanding`=1. A pending `rd_r`=7 followed by a short write to 7 → `stall`=1.
- **FULL:** MAX_OUT=4 long issues with no completions → the fifth long op stalls; a non-long op with independent registers issues.
- **Simultaneous fire and completion** to different registers with `outstanding`=2 → count stays 2, one busy bit set, one cleared.
- **Flush:** with 3 pending plus a same-cycle fire and completion → next cycle `busy_vec`=0, `outstanding`=0. A spurious `wb_valid` at count 0 leaves `outstanding`=0.
